ps2_key_tracker: RTL and testbench

Parametrised successor to the keyboard front end. It receives PS/2 frames directly and validates start, odd parity, stop bit and an inter-edge timeout. It decodes E0/F0 prefixes into key events and queues them in a ready/valid FIFO. It also tracks the currently held key and counts distinct key presses, ignoring typematic repeats. It sits between the PS/2 pins and the display/consumer logic in the top-level build.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_frame_rx.sv | 140 ++++++++++++++
 rtl/ps2_key_tracker.sv | 164 ++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix bytes, the queued key-event record and the
// receiver state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, start/data/
// parity/stop FSM and an inter-edge timeout that aborts stalled frames.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 50000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_parity_err_p,
  output logic       o_frame_err_p
);

  localparam int TW = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(FRAME_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] r_clkSync;
  logic [SYNC_STAGES-1:0] r_dataSync;
  logic                   r_clkPrev;
  logic [TW-1:0]          r_idleCnt;
  rx_state_e              r_state;
  rx_state_e              w_nextState;
  logic [7:0]             r_shift;
  logic [2:0]             r_bitCnt;
  logic                   r_parOk;
  logic                   r_byteValid;
  logic                   r_parityErr;
  logic                   r_frameErr;
  logic                   w_clk;
  logic                   w_data;
  logic                   w_fall;
  logic                   w_timeout;
  logic                   w_byteDone;
  logic                   w_perr;
  logic                   w_ferr;

  assign w_clk     = r_clkSync[SYNC_STAGES-1];
  assign w_data    = r_dataSync[SYNC_STAGES-1];
  assign w_fall    = r_clkPrev & ~w_clk;
  assign w_timeout = (r_idleCnt == TIMEOUT_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_clkSync  <= '0;
      r_dataSync <= '0;
      r_clkPrev  <= 1'b0;
    end else begin
      r_clkSync  <= {r_clkSync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dataSync <= {r_dataSync[SYNC_STAGES-2:0], i_ps2_data};
      r_clkPrev  <= w_clk;
    end
  end

  // Saturates so a long-idle bus does not wrap back into a false timeout window.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_idleCnt <= '0;
    else if (w_fall)
      r_idleCnt <= '0;
    else if (!w_timeout)
      r_idleCnt <= r_idleCnt + TW'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_byteDone  = 1'b0;
    w_perr      = 1'b0;
    w_ferr      = 1'b0;
    if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_data) w_nextState = DATA;
          else         w_ferr      = 1'b1;
        end
        DATA: begin
          if (r_bitCnt == 3'd7) w_nextState = PARITY;
        end
        PARITY: w_nextState = STOP;
        STOP: begin
          w_nextState = IDLE;
          w_ferr      = ~w_data;
          w_perr      = ~r_parOk;
          w_byteDone  = w_data & r_parOk;
        end
        default: w_nextState = IDLE;
      endcase
    end else if (r_state != IDLE && w_timeout) begin
      w_nextState = IDLE;
      w_ferr      = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_parOk  <= 1'b0;
    end else if (w_fall) begin
      case (r_state)
        IDLE:   r_bitCnt <= '0;
        DATA: begin
          r_shift  <= {w_data, r_shift[7:1]};
          r_bitCnt <= r_bitCnt + 3'd1;
        end
        PARITY: r_parOk <= ^{w_data, r_shift};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_byteValid <= 1'b0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_byteValid <= w_byteDone;
      r_parityErr <= w_perr;
      r_frameErr  <= w_ferr;
    end
  end

  assign o_byte         = r_shift;
  assign o_byte_valid   = r_byteValid;
  assign o_parity_err_p = r_parityErr;
  assign o_frame_err_p  = r_frameErr;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: decodes E0/F0 prefixes into key events, queues them
// in a ready/valid FIFO and tracks the held key and distinct press count.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_W         = 8,
  parameter int FRAME_TIMEOUT = 50000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overflow,
  input  logic             clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]       w_byte;
  logic             w_byteValid;
  logic             w_perrP;
  logic             w_ferrP;
  logic             r_extPend;
  logic             r_brkPend;
  logic             w_isExt;
  logic             w_isBrk;
  logic             w_emit;
  ps2_event_t       w_event;
  ps2_event_t       w_head;
  ps2_event_t       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_sameKey;
  logic             r_keyHeld;
  logic [7:0]       r_heldCode;
  logic             r_heldExt;
  logic [CNT_W-1:0] r_pressCnt;
  logic             r_parityErr;
  logic             r_frameErr;
  logic             r_overflow;

  ps2_frame_rx #(
    .FRAME_TIMEOUT(FRAME_TIMEOUT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_rx (
    .clock         (clock),
    .resetn        (resetn),
    .i_ps2_clk     (ps2_clk),
    .i_ps2_data    (ps2_data),
    .o_byte        (w_byte),
    .o_byte_valid  (w_byteValid),
    .o_parity_err_p(w_perrP),
    .o_frame_err_p (w_ferrP)
  );

  assign w_isExt = w_byteValid && (w_byte == PS2_EXT_PREFIX);
  assign w_isBrk = w_byteValid && (w_byte == PS2_BREAK_PREFIX);
  assign w_emit  = w_byteValid && !w_isExt && !w_isBrk;
  assign w_event = '{ext: r_extPend, brk: r_brkPend, code: w_byte};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_extPend <= 1'b0;
      r_brkPend <= 1'b0;
    end else if (w_emit) begin
      r_extPend <= 1'b0;
      r_brkPend <= 1'b0;
    end else begin
      if (w_isExt) r_extPend <= 1'b1;
      if (w_isBrk) r_brkPend <= 1'b1;
    end
  end

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop   = !w_empty && ev_ready;
  assign w_push  = w_emit && (!w_full || w_pop);
  assign w_drop  = w_emit && w_full && !w_pop;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= w_event;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  assign w_head   = r_mem[r_rdPtr[AW-1:0]];
  assign ev_valid = !w_empty;
  assign ev_code  = ev_valid ? w_head.code : 8'h00;
  assign ev_ext   = ev_valid & w_head.ext;
  assign ev_break = ev_valid & w_head.brk;

  assign w_sameKey = r_keyHeld && ({r_heldExt, r_heldCode} == {w_event.ext, w_event.code});

  // Typematic repeats of the held key re-emit makes but must not bump the count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_keyHeld  <= 1'b0;
      r_heldCode <= '0;
      r_heldExt  <= 1'b0;
      r_pressCnt <= '0;
    end else if (w_emit) begin
      if (!w_event.brk) begin
        if (!w_sameKey && (r_pressCnt != {CNT_W{1'b1}}))
          r_pressCnt <= r_pressCnt + CNT_W'(1);
        r_keyHeld  <= 1'b1;
        r_heldCode <= w_event.code;
        r_heldExt  <= w_event.ext;
      end else if (w_sameKey) begin
        r_keyHeld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_perrP)      r_parityErr <= 1'b1;
      else if (clr_err) r_parityErr <= 1'b0;
      if (w_ferrP)      r_frameErr  <= 1'b1;
      else if (clr_err) r_frameErr  <= 1'b0;
      if (w_drop)       r_overflow  <= 1'b1;
      else if (clr_err) r_overflow  <= 1'b0;
    end
  end

  assign key_held    = r_keyHeld;
  assign held_code   = r_heldCode;
  assign held_ext    = r_heldExt;
  assign press_count = r_pressCnt;
  assign parity_err  = r_parityErr;
  assign frame_err   = r_frameErr;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: stimulus sends PS/2 frames and queues
// expected events; a negedge monitor compares every accepted FIFO head.
module tb_ps2_key_tracker;

  localparam int TO = 200;
  localparam int HB = 8;

  logic       clock;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       key_held;
  logic [7:0] held_code;
  logic       held_ext;
  logic [7:0] press_count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
  logic       clr_err;

  logic [9:0] expQ[$];
  int passCount  = 0;
  int checkCount = 0;

  ps2_key_tracker #(
    .FIFO_DEPTH(8), .CNT_W(8), .FRAME_TIMEOUT(TO), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .key_held(key_held),
    .held_code(held_code), .held_ext(held_ext), .press_count(press_count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
    .clr_err(clr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // mode: 0 good, 1 bad parity, 2 stop bit 0, 3 start + 3 data bits only,
  // 4 good frame with a one-cycle ev_ready pulse aligned to the event push
  task automatic applyStimulus(input logic [7:0] b, input int mode);
    logic [10:0] bits;
    logic        par;
    int          n;
    par  = ~(^b);
    if (mode == 1) par = ~par;
    bits = {(mode == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
    n    = (mode == 3) ? 4 : 11;
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      waitCycles(HB);
      ps2_clk = 1'b0;
      if (mode == 4 && i == 10) begin
        repeat (3) @(posedge clock);
        #1 ev_ready = 1'b1;
        @(posedge clock);
        #1 ev_ready = 1'b0;
        waitCycles(HB - 4);
      end else begin
        waitCycles(HB);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    waitCycles(HB);
  endtask

  always @(negedge clock) begin
    if (resetn && ev_valid && ev_ready) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_event: got %0h expected none",
                 {ev_ext, ev_break, ev_code});
      end else begin
        checkOutput("event", {22'd0, ev_ext, ev_break, ev_code}, {22'd0, expQ.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] codes [9];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    resetn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; ev_ready = 1'b0; clr_err = 1'b0;
    waitCycles(5);
    checkOutput("rst_ev_valid", ev_valid, 0);
    checkOutput("rst_ev_code", ev_code, 0);
    checkOutput("rst_key_held", key_held, 0);
    checkOutput("rst_press_count", press_count, 0);
    checkOutput("rst_errs", {parity_err, frame_err, overflow}, 0);
    resetn = 1'b1;
    waitCycles(5);
    ev_ready = 1'b1;

    expQ.push_back({2'b00, 8'h1C});
    applyStimulus(8'h1C, 0); waitCycles(4);
    checkOutput("make_count", press_count, 1);
    checkOutput("make_held", key_held, 1);
    checkOutput("make_code", held_code, 8'h1C);
    checkOutput("make_ext", held_ext, 0);

    applyStimulus(8'hF0, 0);
    expQ.push_back({2'b01, 8'h1C});
    applyStimulus(8'h1C, 0); waitCycles(4);
    checkOutput("brk_held", key_held, 0);
    checkOutput("brk_count", press_count, 1);
    checkOutput("brk_code_kept", held_code, 8'h1C);

    applyStimulus(8'hE0, 0);
    expQ.push_back({2'b10, 8'h75});
    applyStimulus(8'h75, 0); waitCycles(4);
    checkOutput("ext_count", press_count, 2);
    checkOutput("ext_held", {key_held, held_ext, held_code}, {2'b11, 8'h75});
    applyStimulus(8'hE0, 0);
    applyStimulus(8'hF0, 0);
    expQ.push_back({2'b11, 8'h75});
    applyStimulus(8'h75, 0); waitCycles(4);
    checkOutput("ext_brk_held", key_held, 0);
    checkOutput("ext_brk_count", press_count, 2);

    for (int i = 0; i < 3; i++) begin
      expQ.push_back({2'b00, 8'h1B});
      applyStimulus(8'h1B, 0);
    end
    waitCycles(4);
    checkOutput("repeat_count", press_count, 3);
    checkOutput("repeat_held", {key_held, held_code}, {1'b1, 8'h1B});

    applyStimulus(8'h1C, 1); waitCycles(4);
    checkOutput("perr_flags", {parity_err, frame_err}, 2'b10);
    applyStimulus(8'h1C, 2); waitCycles(4);
    checkOutput("stop_ferr", frame_err, 1);
    clr_err = 1'b1; waitCycles(1); clr_err = 1'b0; waitCycles(1);
    checkOutput("clr_flags", {parity_err, frame_err}, 2'b00);
    applyStimulus(8'h1C, 3); waitCycles(4);
    checkOutput("pre_timeout", frame_err, 0);
    waitCycles(TO);
    checkOutput("timeout_ferr", frame_err, 1);
    expQ.push_back({2'b00, 8'h1C});
    applyStimulus(8'h1C, 0); waitCycles(4);
    checkOutput("post_to_count", press_count, 4);
    checkOutput("post_to_code", held_code, 8'h1C);
    checkOutput("post_to_perr_ovf", {parity_err, overflow}, 2'b00);
    clr_err = 1'b1; waitCycles(1); clr_err = 1'b0; waitCycles(1);
    checkOutput("clr_ferr", frame_err, 0);

    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expQ.push_back({2'b00, codes[i]});
      applyStimulus(codes[i], 0);
    end
    waitCycles(4);
    checkOutput("full_overflow", overflow, 1);
    checkOutput("full_head", {ev_valid, ev_code}, {1'b1, 8'h15});
    checkOutput("full_count", press_count, 13);

    expQ.push_back({2'b00, 8'h4B});
    applyStimulus(8'h4B, 4); waitCycles(2);
    checkOutput("pushpop_head", ev_code, 8'h1D);
    checkOutput("pushpop_count", press_count, 14);
    ev_ready = 1'b1;
    waitCycles(20);
    checkOutput("drain_valid", ev_valid, 0);
    checkOutput("drain_forced_zero", {ev_ext, ev_break, ev_code}, 0);
    checkOutput("drain_queue", expQ.size(), 0);

    applyStimulus(8'h29, 3);
    resetn = 1'b0; waitCycles(2);
    checkOutput("midrst_ev", {ev_valid, ev_code}, 0);
    checkOutput("midrst_held", {key_held, held_ext, held_code}, 0);
    checkOutput("midrst_count", press_count, 0);
    checkOutput("midrst_errs", {parity_err, frame_err, overflow}, 0);
    resetn = 1'b1; waitCycles(5);
    expQ.push_back({2'b00, 8'h29});
    applyStimulus(8'h29, 0); waitCycles(10);
    checkOutput("after_rst_count", press_count, 1);
    checkOutput("final_queue", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
